m68k_bus_responder: RTL and testbench
=====================================

Name: m68k_bus_responder

Overview:
- Bus-target counterpart to the DTACK/MCCLK sampling logic.
- Watches a 68000-style asynchronous bus (AS/UDS/LDS/RW/address) from the external master and decodes accesses to a parameterised address window.
- Forwards each decoded access to a local req/ack port, inserts wait states counted in MCCLK falling edges, then drives DTACK_N (or BERR_N on timeout) back to the master.
- Used for bench emulation of slow chip-bus targets and for FPGA-resident registers exposed on the bus.

Parameters:
- BASE_ADDR, 24'hDE0000, window base; bit 0 ignored.
- ADDR_MASK, 24'hFF0000, address bits compared against BASE_ADDR.
- WAIT_STATES, 2, MCCLK falling edges inserted after local ack before DTACK; 0 = none.
- TIMEOUT, 255, SYSCLK cycles allowed for LOCAL_ACK before BERR; range 1..255.

Ports:
- SYSCLK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- MCCLK  in  1  raw bus clock; asynchronous to SYSCLK.
- AS_N  in  1  address strobe; asynchronous.
- UDS_N  in  1  upper data strobe; asynchronous.
- LDS_N  in  1  lower data strobe; asynchronous.
- RW  in  1  1 = read, 0 = write.
- ADDR  in  23  bus address bits 23:1.
- DATA_IN  in  16  bus write data.
- DTACK_N  out  1  data acknowledge to master.
- BERR_N  out  1  bus error to master.
- DATA_OUT  out  16  read data.
- DATA_OE  out  1  read-data output enable.
- LOCAL_REQ  out  1  local access request.
- LOCAL_WE  out  1  1 = write.
- LOCAL_ADDR  out  23  captured address.
- LOCAL_BE  out  2  byte enables: [1] = upper, [0] = lower.
- LOCAL_WDATA  out  16  captured write data.
- LOCAL_ACK  in  1  local completion; single-cycle pulse or level.
- LOCAL_RDATA  in  16  read data, valid when LOCAL_ACK = 1.

Behaviour:
- Synchronisation:
  - AS_N, UDS_N, LDS_N and MCCLK each pass through a 2-FF synchroniser.
  - MCCLK falling edge = synchronised previous 1 and current 0.
  - ADDR, RW and DATA_IN are sampled only in the cycle the access is accepted. They are stable by then because the strobes have already been synchronised.
- Reset (asynchronous, RESET_N = 0):
  - DTACK_N = 1, BERR_N = 1, DATA_OE = 0, DATA_OUT = 0.
  - LOCAL_REQ = 0, LOCAL_WE = 0, LOCAL_ADDR = 0, LOCAL_BE = 0, LOCAL_WDATA = 0.
  - Counters = 0, state = IDLE.
  - Reset asserted mid-cycle releases DTACK_N/BERR_N immediately.
- IDLE:
  - Accept when sync AS_N = 0, at least one sync DS = 0, and ({ADDR,1'b0} & ADDR_MASK) == (BASE_ADDR & ADDR_MASK).
  - On accept, capture LOCAL_ADDR = ADDR, LOCAL_WE = ~RW, LOCAL_BE = {~UDS_N, ~LDS_N}, and LOCAL_WDATA = DATA_IN when writing. Go to REQ.
  - Non-matching accesses are ignored: no output change. Stay in IDLE until AS_N returns high, so the same cycle is not re-evaluated.
- REQ:
  - LOCAL_REQ = 1 next cycle; request fields held stable.
  - On LOCAL_ACK = 1: LOCAL_REQ = 0; for reads, DATA_OUT = LOCAL_RDATA and DATA_OE = 1. Go to WAIT.
  - Timeout counter increments each REQ cycle. When it reaches TIMEOUT without ack: LOCAL_REQ = 0, BERR_N = 0, go to TERM.
  - An ack arriving in the same cycle as the timeout wins; no BERR.
- WAIT:
  - Count MCCLK falling edges. When count == WAIT_STATES: DTACK_N = 0, go to TERM.
  - With WAIT_STATES = 0, DTACK_N = 0 in the cycle after ack.
- TERM:
  - Hold DTACK_N or BERR_N low until sync AS_N = 1.
  - Then in one cycle: DTACK_N = 1, BERR_N = 1, DATA_OE = 0. Go to IDLE. DATA_OUT retains its value.
- Abort (sync AS_N = 1 before DTACK/BERR):
  - In WAIT: return to IDLE, DATA_OE = 0, no DTACK.
  - In REQ: keep LOCAL_REQ until ack or timeout (handshake never dropped), discard result, then IDLE with no DTACK/BERR.
- Invariants:
  - DTACK_N and BERR_N are never both 0.
  - LOCAL_REQ is never reasserted in the cycle it drops.
  - Back-to-back bus cycles require AS_N high for at least one synchronised sample between them.

Test Plan:
- Read at 0xDE0010 (UDS and LDS low), LOCAL_ACK after 3 cycles with RDATA = 0xA55A, WAIT_STATES = 2 → LOCAL_BE = 2'b11, LOCAL_WE = 0; DATA_OE = 1 with DATA_OUT = 0xA55A before DTACK_N falls; DTACK_N falls exactly on the 2nd MCCLK fall after ack; DTACK_N and DATA_OE return to 1/0 within 3 cycles of AS_N rising.
- Byte write to 0xDE0003 (LDS only), DATA_IN = 0x12EF → LOCAL_WE = 1, LOCAL_BE = 2'b01, LOCAL_WDATA = 0x12EF, LOCAL_ADDR = 0x6F0001; DATA_OE stays 0.
- Access to 0xC00000 → no LOCAL_REQ, DTACK_N and BERR_N stay 1 for the whole cycle.
- LOCAL_ACK withheld, TIMEOUT = 16 → LOCAL_REQ drops and BERR_N = 0 at the 16th REQ cycle; DTACK_N stays 1; BERR_N releases after AS_N rises.
- AS_N raised during REQ, ack 5 cycles later → LOCAL_REQ holds until ack, then IDLE; no DTACK, DATA_OE stays 0.
- RESET_N pulsed low while DTACK_N = 0 → DTACK_N = 1 asynchronously; next valid cycle completes normally.

Source files
------------

// File: rtl/m68k_bus_responder.sv
// m68k_bus_responder: bus-target side of a 68000-style asynchronous bus.
// Decodes an address window and forwards hits to a local req/ack port.
// After the local ack it waits a set number of MCCLK falling edges, then
// answers the master with DTACK_N, or with BERR_N if the local side never acks.
module m68k_bus_responder #(
  parameter logic [23:0] BASE_ADDR   = 24'hDE0000,
  parameter logic [23:0] ADDR_MASK   = 24'hFF0000,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic        SYSCLK,
  input  logic        RESET_N,
  input  logic        MCCLK,
  input  logic        AS_N,
  input  logic        UDS_N,
  input  logic        LDS_N,
  input  logic        RW,
  input  logic [22:0] ADDR,
  input  logic [15:0] DATA_IN,
  output logic        DTACK_N,
  output logic        BERR_N,
  output logic [15:0] DATA_OUT,
  output logic        DATA_OE,
  output logic        LOCAL_REQ,
  output logic        LOCAL_WE,
  output logic [22:0] LOCAL_ADDR,
  output logic [1:0]  LOCAL_BE,
  output logic [15:0] LOCAL_WDATA,
  input  logic        LOCAL_ACK,
  input  logic [15:0] LOCAL_RDATA
);

  localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);
  localparam logic [7:0] WS_LIMIT = 8'(WAIT_STATES);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT, ST_TERM} state_t;

  state_t      r_state, w_stateNext;
  logic [1:0]  r_asSync, r_udsSync, r_ldsSync, r_mcSync;
  logic        r_mcPrev;
  logic        r_ignore, w_ignoreNext;
  logic        r_abort, w_abortNext;
  logic [7:0]  r_toCnt, w_toCntNext;
  logic [7:0]  r_wsCnt, w_wsCntNext;
  logic        r_dtackN, w_dtackNNext;
  logic        r_berrN, w_berrNNext;
  logic [15:0] r_dataOut, w_dataOutNext;
  logic        r_dataOe, w_dataOeNext;
  logic        r_localReq, w_localReqNext;
  logic        r_localWe, w_localWeNext;
  logic [22:0] r_localAddr, w_localAddrNext;
  logic [1:0]  r_localBe, w_localBeNext;
  logic [15:0] r_localWdata, w_localWdataNext;

  logic        w_asN, w_dsActive, w_match, w_mcFall, w_abortNow;
  logic [7:0]  w_toInc, w_wsInc;

  assign w_asN      = r_asSync[1];
  assign w_dsActive = ~r_udsSync[1] | ~r_ldsSync[1];
  assign w_match    = (({ADDR, 1'b0} & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
  assign w_mcFall   = r_mcPrev & ~r_mcSync[1];
  assign w_abortNow = r_abort | w_asN;
  assign w_toInc    = r_toCnt + 8'd1;
  assign w_wsInc    = r_wsCnt + 8'd1;

  // Two-flop synchronisers for the asynchronous strobes and MCCLK, plus MCCLK history for edge detection.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_asSync  <= 2'b11;
      r_udsSync <= 2'b11;
      r_ldsSync <= 2'b11;
      r_mcSync  <= 2'b11;
      r_mcPrev  <= 1'b1;
    end else begin
      r_asSync  <= {r_asSync[0], AS_N};
      r_udsSync <= {r_udsSync[0], UDS_N};
      r_ldsSync <= {r_ldsSync[0], LDS_N};
      r_mcSync  <= {r_mcSync[0], MCCLK};
      r_mcPrev  <= r_mcSync[1];
    end
  end

  // Bus-cycle state and registered outputs.
  always_ff @(posedge SYSCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= ST_IDLE;
      r_ignore     <= 1'b0;
      r_abort      <= 1'b0;
      r_toCnt      <= '0;
      r_wsCnt      <= '0;
      r_dtackN     <= 1'b1;
      r_berrN      <= 1'b1;
      r_dataOut    <= '0;
      r_dataOe     <= 1'b0;
      r_localReq   <= 1'b0;
      r_localWe    <= 1'b0;
      r_localAddr  <= '0;
      r_localBe    <= '0;
      r_localWdata <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_ignore     <= w_ignoreNext;
      r_abort      <= w_abortNext;
      r_toCnt      <= w_toCntNext;
      r_wsCnt      <= w_wsCntNext;
      r_dtackN     <= w_dtackNNext;
      r_berrN      <= w_berrNNext;
      r_dataOut    <= w_dataOutNext;
      r_dataOe     <= w_dataOeNext;
      r_localReq   <= w_localReqNext;
      r_localWe    <= w_localWeNext;
      r_localAddr  <= w_localAddrNext;
      r_localBe    <= w_localBeNext;
      r_localWdata <= w_localWdataNext;
    end
  end

  // Next-state logic: accept, local handshake, wait states, termination and abort handling.
  always_comb begin
    w_stateNext      = r_state;
    w_ignoreNext     = r_ignore;
    w_abortNext      = r_abort;
    w_toCntNext      = r_toCnt;
    w_wsCntNext      = r_wsCnt;
    w_dtackNNext     = r_dtackN;
    w_berrNNext      = r_berrN;
    w_dataOutNext    = r_dataOut;
    w_dataOeNext     = r_dataOe;
    w_localReqNext   = r_localReq;
    w_localWeNext    = r_localWe;
    w_localAddrNext  = r_localAddr;
    w_localBeNext    = r_localBe;
    w_localWdataNext = r_localWdata;
    case (r_state)
      ST_IDLE: begin
        if (w_asN) begin
          w_ignoreNext = 1'b0;
        end else if (!r_ignore && w_dsActive) begin
          if (w_match) begin
            w_localAddrNext = ADDR;
            w_localWeNext   = ~RW;
            w_localBeNext   = {~r_udsSync[1], ~r_ldsSync[1]};
            if (!RW) w_localWdataNext = DATA_IN;
            w_localReqNext  = 1'b1;
            w_toCntNext     = '0;
            w_abortNext     = 1'b0;
            w_stateNext     = ST_REQ;
          end else begin
            w_ignoreNext = 1'b1;
          end
        end
      end
      ST_REQ: begin
        w_toCntNext = w_toInc;
        w_abortNext = w_abortNow;
        if (LOCAL_ACK) begin
          w_localReqNext = 1'b0;
          if (w_abortNow) begin
            w_stateNext = ST_IDLE;
          end else begin
            if (!r_localWe) begin
              w_dataOutNext = LOCAL_RDATA;
              w_dataOeNext  = 1'b1;
            end
            w_wsCntNext = '0;
            if (WS_LIMIT == 8'd0) begin
              w_dtackNNext = 1'b0;
              w_stateNext  = ST_TERM;
            end else begin
              w_stateNext = ST_WAIT;
            end
          end
        end else if (w_toInc == TO_LIMIT) begin
          w_localReqNext = 1'b0;
          if (w_abortNow) begin
            w_stateNext = ST_IDLE;
          end else begin
            w_berrNNext = 1'b0;
            w_stateNext = ST_TERM;
          end
        end
      end
      ST_WAIT: begin
        if (w_asN) begin
          w_dataOeNext = 1'b0;
          w_stateNext  = ST_IDLE;
        end else if (w_mcFall) begin
          w_wsCntNext = w_wsInc;
          if (w_wsInc == WS_LIMIT) begin
            w_dtackNNext = 1'b0;
            w_stateNext  = ST_TERM;
          end
        end
      end
      default: begin
        if (w_asN) begin
          w_dtackNNext = 1'b1;
          w_berrNNext  = 1'b1;
          w_dataOeNext = 1'b0;
          w_stateNext  = ST_IDLE;
        end
      end
    endcase
  end

  assign DTACK_N     = r_dtackN;
  assign BERR_N      = r_berrN;
  assign DATA_OUT    = r_dataOut;
  assign DATA_OE     = r_dataOe;
  assign LOCAL_REQ   = r_localReq;
  assign LOCAL_WE    = r_localWe;
  assign LOCAL_ADDR  = r_localAddr;
  assign LOCAL_BE    = r_localBe;
  assign LOCAL_WDATA = r_localWdata;

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Testbench for m68k_bus_responder: directed bus cycles with a request scoreboard.
module tb_m68k_bus_responder;

  localparam logic [23:0] TB_BASE = 24'hDE0000;
  localparam logic [23:0] TB_MASK = 24'hFF0000;

  logic        SYSCLK = 1'b0;
  logic        RESET_N, MCCLK, AS_N, UDS_N, LDS_N, RW;
  logic [22:0] ADDR;
  logic [15:0] DATA_IN;
  logic        DTACK_N, BERR_N, DATA_OE, LOCAL_REQ, LOCAL_WE, LOCAL_ACK;
  logic [15:0] DATA_OUT, LOCAL_WDATA, LOCAL_RDATA;
  logic [22:0] LOCAL_ADDR;
  logic [1:0]  LOCAL_BE;

  typedef struct packed {
    logic        we;
    logic [22:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } req_t;

  req_t        reqQueue[$];
  logic [15:0] rdataQueue[$];
  int          testCount = 0;
  int          failCount = 0;

  m68k_bus_responder #(
    .BASE_ADDR(TB_BASE), .ADDR_MASK(TB_MASK), .WAIT_STATES(2), .TIMEOUT(16)
  ) dut (
    .SYSCLK(SYSCLK), .RESET_N(RESET_N), .MCCLK(MCCLK), .AS_N(AS_N),
    .UDS_N(UDS_N), .LDS_N(LDS_N), .RW(RW), .ADDR(ADDR), .DATA_IN(DATA_IN),
    .DTACK_N(DTACK_N), .BERR_N(BERR_N), .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE),
    .LOCAL_REQ(LOCAL_REQ), .LOCAL_WE(LOCAL_WE), .LOCAL_ADDR(LOCAL_ADDR),
    .LOCAL_BE(LOCAL_BE), .LOCAL_WDATA(LOCAL_WDATA), .LOCAL_ACK(LOCAL_ACK),
    .LOCAL_RDATA(LOCAL_RDATA)
  );

  // 100 MHz system clock
  always #5 SYSCLK = ~SYSCLK;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Starts a bus cycle; matching accesses push their expected local request.
  task automatic applyStimulus(input logic [23:0] byteAddr, input logic rw,
                               input logic udsN, input logic ldsN, input logic [15:0] data);
    req_t exp;
    ADDR = byteAddr[23:1];
    RW = rw;
    DATA_IN = data;
    UDS_N = udsN;
    LDS_N = ldsN;
    AS_N = 1'b0;
    if ((byteAddr & TB_MASK) == (TB_BASE & TB_MASK)) begin
      exp.we = ~rw;
      exp.addr = byteAddr[23:1];
      exp.be = {~udsN, ~ldsN};
      exp.wdata = data;
      reqQueue.push_back(exp);
    end
  endtask

  task automatic endBusCycle();
    AS_N = 1'b1;
    UDS_N = 1'b1;
    LDS_N = 1'b1;
  endtask

  // Waits (bounded) for LOCAL_REQ, then compares the request against the scoreboard.
  task automatic checkRequest(input string tag);
    req_t exp;
    int n = 0;
    while (LOCAL_REQ !== 1'b1 && n < 50) begin
      @(negedge SYSCLK);
      n++;
    end
    checkOutput({tag, "_req"}, 32'(LOCAL_REQ), 32'd1);
    if (reqQueue.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 32'(reqQueue.size()), 32'd1);
    end else begin
      exp = reqQueue.pop_front();
      checkOutput({tag, "_we"}, 32'(LOCAL_WE), 32'(exp.we));
      checkOutput({tag, "_addr"}, 32'(LOCAL_ADDR), 32'(exp.addr));
      checkOutput({tag, "_be"}, 32'(LOCAL_BE), 32'(exp.be));
      if (exp.we) checkOutput({tag, "_wdata"}, 32'(LOCAL_WDATA), 32'(exp.wdata));
    end
  endtask

  task automatic ackPulse(input logic [15:0] rdata, input logic isRead);
    LOCAL_ACK = 1'b1;
    LOCAL_RDATA = rdata;
    if (isRead) rdataQueue.push_back(rdata);
    @(negedge SYSCLK);
    LOCAL_ACK = 1'b0;
  endtask

  task automatic checkReadData(input string tag);
    if (rdataQueue.size() == 0) begin
      checkOutput({tag, "_rd_sb_empty"}, 32'(rdataQueue.size()), 32'd1);
    end else begin
      checkOutput({tag, "_data_out"}, 32'(DATA_OUT), 32'(rdataQueue.pop_front()));
    end
  endtask

  task automatic mcPulse();
    MCCLK = 1'b0;
    repeat (4) @(negedge SYSCLK);
    MCCLK = 1'b1;
    repeat (4) @(negedge SYSCLK);
  endtask

  task automatic waitDtack(input string tag, input logic level);
    int n = 0;
    while (DTACK_N !== level && n < 40) begin
      @(negedge SYSCLK);
      n++;
    end
    checkOutput(tag, 32'(DTACK_N), 32'(level));
  endtask

  initial begin
    int reqCycles;
    int sawActivity;
    logic stayed;
    RESET_N = 1'b0; MCCLK = 1'b1; AS_N = 1'b1; UDS_N = 1'b1; LDS_N = 1'b1;
    RW = 1'b1; ADDR = '0; DATA_IN = '0; LOCAL_ACK = 1'b0; LOCAL_RDATA = '0;
    repeat (3) @(negedge SYSCLK);
    checkOutput("rst_dtack", 32'(DTACK_N), 32'd1);
    checkOutput("rst_berr", 32'(BERR_N), 32'd1);
    checkOutput("rst_oe", 32'(DATA_OE), 32'd0);
    checkOutput("rst_dout", 32'(DATA_OUT), 32'd0);
    checkOutput("rst_req", 32'(LOCAL_REQ), 32'd0);
    checkOutput("rst_laddr", 32'(LOCAL_ADDR), 32'd0);
    checkOutput("rst_be", 32'(LOCAL_BE), 32'd0);
    RESET_N = 1'b1;
    repeat (3) @(negedge SYSCLK);

    // Word read with two wait states
    applyStimulus(24'hDE0010, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge SYSCLK);
    checkRequest("rd");
    repeat (2) @(negedge SYSCLK);
    ackPulse(16'hA55A, 1'b1);
    checkOutput("rd_req_drop", 32'(LOCAL_REQ), 32'd0);
    checkOutput("rd_oe_early", 32'(DATA_OE), 32'd1);
    checkOutput("rd_dtack_pre", 32'(DTACK_N), 32'd1);
    checkReadData("rd");
    mcPulse();
    checkOutput("rd_dtack_1st_fall", 32'(DTACK_N), 32'd1);
    MCCLK = 1'b0;
    repeat (2) @(negedge SYSCLK);
    checkOutput("rd_dtack_before_2nd", 32'(DTACK_N), 32'd1);
    @(negedge SYSCLK);
    checkOutput("rd_dtack_2nd_fall", 32'(DTACK_N), 32'd0);
    checkOutput("rd_berr_idle", 32'(BERR_N), 32'd1);
    MCCLK = 1'b1;
    repeat (3) @(negedge SYSCLK);
    checkOutput("rd_dtack_hold", 32'(DTACK_N), 32'd0);
    endBusCycle();
    repeat (3) @(negedge SYSCLK);
    checkOutput("rd_dtack_release", 32'(DTACK_N), 32'd1);
    checkOutput("rd_oe_release", 32'(DATA_OE), 32'd0);
    checkOutput("rd_dout_retained", 32'(DATA_OUT), 32'hA55A);
    repeat (2) @(negedge SYSCLK);

    // Lower-byte write
    applyStimulus(24'hDE0003, 1'b0, 1'b1, 1'b0, 16'h12EF);
    @(negedge SYSCLK);
    checkRequest("wr");
    checkOutput("wr_laddr_abs", 32'(LOCAL_ADDR), 32'h6F0001);
    @(negedge SYSCLK);
    ackPulse(16'hFFFF, 1'b0);
    checkOutput("wr_oe", 32'(DATA_OE), 32'd0);
    mcPulse();
    mcPulse();
    waitDtack("wr_dtack", 1'b0);
    checkOutput("wr_oe_dtack", 32'(DATA_OE), 32'd0);
    endBusCycle();
    waitDtack("wr_dtack_release", 1'b1);
    repeat (2) @(negedge SYSCLK);

    // Access outside the window is ignored
    applyStimulus(24'hC00000, 1'b1, 1'b0, 1'b0, 16'h0000);
    sawActivity = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge SYSCLK);
      if (LOCAL_REQ !== 1'b0 || DTACK_N !== 1'b1 || BERR_N !== 1'b1) sawActivity++;
    end
    checkOutput("miss_no_activity", 32'(sawActivity), 32'd0);
    endBusCycle();
    repeat (4) @(negedge SYSCLK);

    // Local side never acks: bus error after 16 request cycles
    applyStimulus(24'hDE0100, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge SYSCLK);
    checkRequest("to");
    reqCycles = 0;
    while (LOCAL_REQ === 1'b1 && reqCycles < 40) begin
      reqCycles++;
      @(negedge SYSCLK);
    end
    checkOutput("to_req_cycles", 32'(reqCycles), 32'd16);
    checkOutput("to_berr", 32'(BERR_N), 32'd0);
    checkOutput("to_dtack", 32'(DTACK_N), 32'd1);
    repeat (3) @(negedge SYSCLK);
    checkOutput("to_berr_hold", 32'(BERR_N), 32'd0);
    endBusCycle();
    repeat (3) @(negedge SYSCLK);
    checkOutput("to_berr_release", 32'(BERR_N), 32'd1);
    repeat (2) @(negedge SYSCLK);

    // Master aborts during REQ; handshake completes silently
    applyStimulus(24'hDE0020, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge SYSCLK);
    checkRequest("ab");
    endBusCycle();
    stayed = 1'b1;
    repeat (5) begin
      @(negedge SYSCLK);
      if (LOCAL_REQ !== 1'b1) stayed = 1'b0;
    end
    checkOutput("ab_req_held", 32'(stayed), 32'd1);
    ackPulse(16'h5555, 1'b0);
    checkOutput("ab_req_drop", 32'(LOCAL_REQ), 32'd0);
    sawActivity = 0;
    for (int i = 0; i < 12; i++) begin
      if (DTACK_N !== 1'b1 || BERR_N !== 1'b1 || DATA_OE !== 1'b0 || LOCAL_REQ !== 1'b0) sawActivity++;
      @(negedge SYSCLK);
    end
    checkOutput("ab_silent", 32'(sawActivity), 32'd0);

    // Reset while DTACK_N is asserted, then a normal cycle
    applyStimulus(24'hDE0030, 1'b1, 1'b0, 1'b0, 16'h0000);
    @(negedge SYSCLK);
    checkRequest("rs1");
    ackPulse(16'hBEEF, 1'b1);
    checkReadData("rs1");
    mcPulse();
    mcPulse();
    waitDtack("rs1_dtack", 1'b0);
    RESET_N = 1'b0;
    #1;
    checkOutput("rs_async_dtack", 32'(DTACK_N), 32'd1);
    checkOutput("rs_async_oe", 32'(DATA_OE), 32'd0);
    @(negedge SYSCLK);
    endBusCycle();
    repeat (2) @(negedge SYSCLK);
    RESET_N = 1'b1;
    repeat (3) @(negedge SYSCLK);
    applyStimulus(24'hDE0040, 1'b1, 1'b0, 1'b1, 16'h0000);
    @(negedge SYSCLK);
    checkRequest("rs2");
    ackPulse(16'h1234, 1'b1);
    checkOutput("rs2_oe", 32'(DATA_OE), 32'd1);
    checkReadData("rs2");
    mcPulse();
    mcPulse();
    waitDtack("rs2_dtack", 1'b0);
    endBusCycle();
    waitDtack("rs2_dtack_release", 1'b1);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
